// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle shift-add multiply / restoring divide owning the HI/LO registers
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startE,
    input  logic [5:0]       functE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    output logic [WIDTH-1:0] hiloE,
    output logic             busyE,
    output logic             stallMD
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} stateT;
    stateT state, stateNext;
    logic [WIDTH-1:0] hi, lo, acc, quo, mcand, magA, magB, divDiff;
    logic [CW-1:0] cnt;
    logic negQ, negR, divOp, divZero, isMulDiv, sgn, divFits;
    logic [WIDTH:0] mulSum, divShift;
    logic [2*WIDTH-1:0] prod;
    always_comb begin
        isMulDiv = functE[5:2] == 4'b0110;
        sgn = ~functE[0];
        magA = (sgn && srcaE[WIDTH-1]) ? -srcaE : srcaE;
        magB = (sgn && srcbE[WIDTH-1]) ? -srcbE : srcbE;
        mulSum = {1'b0, acc} + (quo[0] ? {1'b0, mcand} : '0);
        divShift = {acc, quo[WIDTH-1]};
        divFits = divShift >= {1'b0, mcand};
        divDiff = divShift[WIDTH-1:0] - mcand;
        prod = {acc, quo};
        stateNext = state == IDLE ? ((startE && isMulDiv) ? (functE[1] ? DIV : MUL) : IDLE)
                  : state == FIX ? IDLE
                  : (cnt == CW'(1) ? FIX : state);
    end
    always_ff @(posedge clk)
        if (reset) state <= IDLE;
        else state <= stateNext;
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
            acc <= '0;
            quo <= '0;
            mcand <= '0;
            cnt <= '0;
            negQ <= 1'b0;
            negR <= 1'b0;
            divOp <= 1'b0;
            divZero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (startE) begin
                    if (isMulDiv) begin
                        acc <= '0;
                        quo <= functE[1] ? magA : magB;
                        mcand <= functE[1] ? magB : magA;
                        cnt <= CW'(WIDTH);
                        negQ <= sgn & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
                        negR <= sgn & srcaE[WIDTH-1];
                        divOp <= functE[1];
                        divZero <= srcbE == '0;
                    end else if (functE == 6'b010001) hi <= srcaE;
                    else if (functE == 6'b010011) lo <= srcaE;
                end
                MUL: begin
                    acc <= mulSum[WIDTH:1];
                    quo <= {mulSum[0], quo[WIDTH-1:1]};
                    cnt <= cnt - CW'(1);
                end
                DIV: begin
                    acc <= divFits ? divDiff : divShift[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], divFits};
                    cnt <= cnt - CW'(1);
                end
                default: if (divOp) begin
                    // a zero divisor leaves the dividend magnitude in acc, so sign-restoring it yields srcaE
                    lo <= divZero ? '1 : (negQ ? -quo : quo);
                    hi <= negR ? -acc : acc;
                end else {hi, lo} <= negQ ? -prod : prod;
            endcase
        end
    end
    assign hiloE = functE == 6'b010000 ? hi : lo;
    assign busyE = state != IDLE;
    assign stallMD = busyE & startE;
endmodule
